// File: rtl/bus_reg_responder_pkg.sv
// Shared definitions for the register-file bus protocol: default widths and the
// FSM state encoding used by both responder and initiator sides.
package bus_reg_responder_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DRIVE = 2'd1,
        TURN     = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_reg_responder.sv
// Responder side of the shared-bus register file: stores writes, drives read data
// for one cycle, enforces a turnaround cycle, flags collisions and counts accesses.
module bus_reg_responder
    import bus_reg_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    state_e            state_d, state_q;
    logic [DATA_W-1:0] bus_out_d, bus_out_q;
    logic              bus_oe_d, bus_oe_q;
    logic              rd_valid_d, rd_valid_q;
    logic              err_d, err_q;
    logic              wr_en;
    logic              rd_inc;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        bus_out_d  = bus_out_q;
        bus_oe_d   = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        wr_en      = 1'b0;
        rd_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (we && re) begin
                    err_d = 1'b1;
                end else if (we) begin
                    wr_en = 1'b1;
                end else if (re) begin
                    bus_out_d  = mem_q[addr];
                    bus_oe_d   = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_inc     = 1'b1;
                    state_d    = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                // Any write attempt while we own the bus is a collision and ends the drive.
                if (we) begin
                    err_d   = 1'b1;
                    state_d = TURN;
                end else if (re) begin
                    bus_out_d  = mem_q[addr];
                    bus_oe_d   = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_inc     = 1'b1;
                end else begin
                    state_d = TURN;
                end
            end
            TURN: begin
                if (we) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the register file must read back zero after reset, so it is built from
    // resettable flops rather than a RAM macro (RAMs cannot be cleared in one cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= bus_in;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_en),
        .count (wr_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_inc),
        .count (rd_count)
    );

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_reg_responder.sv
// Self-checking bench for bus_reg_responder: directed vector table, async-reset
// corner, randomized traffic against a behavioural model, counter saturation.
module tb_bus_reg_responder;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] bus_in = '0;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          rd_valid;
    logic          busy;
    logic          err;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;

    bus_reg_responder dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: "driving" = a read was accepted at the last edge,
    // "turning" = the bus was released at the last edge.
    bit [DW-1:0] m_mem [32];
    bit          m_drv;
    bit          m_turn;
    bit [DW-1:0] m_out;
    bit          m_err;
    int          m_wr;
    int          m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_drv  = 1'b0;
        m_turn = 1'b0;
        m_out  = '0;
        m_err  = 1'b0;
        m_wr   = 0;
        m_rd   = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input int a, input bit [DW-1:0] d);
        bit idle;
        bit drv_n;
        idle  = !m_drv && !m_turn;
        drv_n = 1'b0;
        if (w && r) begin
            m_err = 1'b1;
        end else if (w) begin
            if (idle) begin
                m_mem[a] = d;
                m_wr = (m_wr < CNT_MAX) ? m_wr + 1 : m_wr;
            end else begin
                m_err = 1'b1;
            end
        end else if (r && !m_turn) begin
            m_out = m_mem[a];
            drv_n = 1'b1;
            m_rd = (m_rd < CNT_MAX) ? m_rd + 1 : m_rd;
        end
        m_turn = m_drv && !drv_n;
        m_drv  = drv_n;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".bus_oe"},   bus_oe,   m_drv);
        check({tag, ".rd_valid"}, rd_valid, m_drv);
        check({tag, ".busy"},     busy,     m_drv || m_turn);
        check({tag, ".err"},      err,      m_err);
        check({tag, ".wr_count"}, wr_count, m_wr);
        check({tag, ".rd_count"}, rd_count, m_rd);
        if (m_drv) check({tag, ".bus_out"}, bus_out, m_out);
    endtask

    // Called at posedge+1; drives inputs, advances one edge, leaves time at posedge+1.
    task automatic apply(input bit w, input bit r, input int a, input bit [DW-1:0] d);
        we     = w;
        re     = r;
        addr   = AW'(a);
        bus_in = d;
        model_step(w, r, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we  = 1'b0;
        re  = 1'b0;
        rst = 1'b0;
        model_reset();
        #2;
        check("reset.bus_oe",   bus_oe,   1'b0);
        check("reset.bus_out",  bus_out,  32'h0);
        check("reset.rd_valid", rd_valid, 1'b0);
        check("reset.busy",     busy,     1'b0);
        check("reset.err",      err,      1'b0);
        check("reset.wr_count", wr_count, 32'h0);
        check("reset.rd_count", rd_count, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst_first;
        bit          w;
        bit          r;
        int          a;
        bit [DW-1:0] d;
        bit          e_oe;
        bit [DW-1:0] e_out;
        bit          e_busy;
        bit          e_err;
        int          e_wr;
        int          e_rd;
    } vec_t;

    vec_t vecs [20];

    initial begin
        //              rst w  r  a  din           oe out           busy err wr rd
        vecs[0]  = '{1'b1, 1, 0, 0, 32'hFFFF000F, 0, 32'h0,        0, 0, 1, 0};
        vecs[1]  = '{1'b0, 1, 0, 1, 32'hFFFF000E, 0, 32'h0,        0, 0, 2, 0};
        vecs[2]  = '{1'b0, 0, 1, 1, 32'h0,        1, 32'hFFFF000E, 1, 0, 2, 1};
        vecs[3]  = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 2, 1};
        vecs[4]  = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 2, 1};
        vecs[5]  = '{1'b0, 0, 1, 0, 32'h0,        1, 32'hFFFF000F, 1, 0, 2, 2};
        vecs[6]  = '{1'b0, 0, 1, 1, 32'h0,        1, 32'hFFFF000E, 1, 0, 2, 3};
        vecs[7]  = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 2, 3};
        vecs[8]  = '{1'b0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 2, 3};
        vecs[9]  = '{1'b0, 0, 1, 3, 32'h0,        1, 32'h0,        1, 0, 2, 4};
        vecs[10] = '{1'b0, 1, 0, 3, 32'h12345678, 0, 32'h0,        1, 1, 2, 4};
        vecs[11] = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 2, 4};
        vecs[12] = '{1'b0, 0, 1, 3, 32'h0,        1, 32'h0,        1, 1, 2, 5};
        vecs[13] = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 2, 5};
        vecs[14] = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 2, 5};
        vecs[15] = '{1'b1, 1, 1, 2, 32'h55AA55AA, 0, 32'h0,        0, 1, 0, 0};
        vecs[16] = '{1'b0, 0, 1, 2, 32'h0,        1, 32'h0,        1, 1, 0, 1};
        vecs[17] = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 1};
        vecs[18] = '{1'b0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 1};
        vecs[19] = '{1'b1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0};

        #1;
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rst_first) do_reset();
            apply(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            check({tag, ".bus_oe"},   bus_oe,   vecs[i].e_oe);
            check({tag, ".rd_valid"}, rd_valid, vecs[i].e_oe);
            check({tag, ".busy"},     busy,     vecs[i].e_busy);
            check({tag, ".err"},      err,      vecs[i].e_err);
            check({tag, ".wr_count"}, wr_count, vecs[i].e_wr);
            check({tag, ".rd_count"}, rd_count, vecs[i].e_rd);
            if (vecs[i].e_oe) check({tag, ".bus_out"}, bus_out, vecs[i].e_out);
        end

        // Asynchronous reset while driving the bus must release it before the next edge.
        apply(1, 0, 7, 32'hA5A5A5A5);
        apply(0, 1, 7, 32'h0);
        check("async.pre_oe",  bus_oe,  1'b1);
        check("async.pre_out", bus_out, 32'hA5A5A5A5);
        we = 1'b0;
        re = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async.bus_oe",   bus_oe,   1'b0);
        check("async.rd_valid", rd_valid, 1'b0);
        check("async.busy",     busy,     1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        apply(0, 1, 7, 32'h0);
        check("async.read_oe",  bus_oe,  1'b1);
        check("async.read_out", bus_out, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int  sel;
            bit  w;
            bit  r;
            sel = int'($urandom_range(0, 19));
            w = (sel < 7) || (sel == 19);
            r = (sel >= 7 && sel < 16) || (sel == 19);
            apply(w, r, int'($urandom_range(0, 7)), $urandom);
            check_model($sformatf("rand%0d", i));
        end

        // Write counter saturation.
        do_reset();
        we     = 1'b1;
        re     = 1'b0;
        addr   = 5'd9;
        bus_in = 32'hDEADBEEF;
        repeat (65534) @(posedge clk);
        #1;
        check("sat.wr_65534", wr_count, 32'hFFFE);
        @(posedge clk);
        #1;
        check("sat.wr_65535", wr_count, 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sat.wr_65537", wr_count, 32'hFFFF);
        check("sat.rd_count", rd_count, 32'h0);
        check("sat.err",      err,      1'b0);
        we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
